// File: rtl/multi_edge_debouncer_pkg.sv
// multi_edge_debouncer_pkg: edge-mode codes, board polarity defaults and edge qualification helper
package multi_edge_debouncer_pkg;
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_BOTH    = 2;
    typedef enum logic {BOARD_20K, BOARD_9K} board_e;
    function automatic bit active_low_for(board_e board);
        return board == BOARD_9K;
    endfunction
    function automatic logic edge_qualifies(int mode, logic rising);
        return rising ? (mode != EDGE_FALLING) : (mode != EDGE_RISING);
    endfunction
endpackage

// File: rtl/multi_edge_debouncer_if.sv
// multi_edge_debouncer_if: pin-side inputs and debounced outputs of all channels
interface multi_edge_debouncer_if #(parameter int N_CH = 4);
    logic [N_CH-1:0] sig_in;
    logic [N_CH-1:0] pend_clr;
    logic [N_CH-1:0] pulse;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] pending;
    modport master(output sig_in, pend_clr, input pulse, level, pending);
    modport slave(input sig_in, pend_clr, output pulse, level, pending);
endinterface

// File: rtl/multi_edge_debouncer_ch.sv
// edge_debounce_ch: one channel of synchroniser, debounce counter, level, edge pulse and sticky pending
module edge_debounce_ch
    import multi_edge_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int EDGE_MODE       = EDGE_RISING
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    input  logic pend_clr,
    output logic pulse,
    output logic level,
    output logic pending
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic s1_q, s1_d, s2_q, s2_d;
    logic level_q, level_d, pulse_q, pulse_d, pending_q, pending_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic term;
    always_comb begin
        s1_d      = ACTIVE_LOW ? ~sig_in : sig_in;
        s2_d      = s1_q;
        term      = (s2_q != level_q) && (count_q == CNT_LAST);
        count_d   = (s2_q == level_q || term) ? '0 : count_q + 1'b1;
        level_d   = term ? s2_q : level_q;
        pulse_d   = term && edge_qualifies(EDGE_MODE, s2_q);
        // a set on the same cycle as a clear wins so no event is lost
        pending_d = pulse_d | (pending_q & ~pend_clr);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end
    assign pulse   = pulse_q;
    assign level   = level_q;
    assign pending = pending_q;
endmodule

// File: rtl/multi_edge_debouncer.sv
// multi_edge_debouncer: N independent debounced edge-detect channels
module multi_edge_debouncer
    import multi_edge_debouncer_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter bit ACTIVE_LOW      = active_low_for(BOARD_20K),
    parameter int EDGE_MODE       = EDGE_RISING
) (
    input logic clk,
    input logic reset,
    multi_edge_debouncer_if.slave bus
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .EDGE_MODE      (EDGE_MODE)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .sig_in  (bus.sig_in[i]),
            .pend_clr(bus.pend_clr[i]),
            .pulse   (bus.pulse[i]),
            .level   (bus.level[i]),
            .pending (bus.pending[i])
        );
    end
endmodule
